// File: rtl/lcd_view_ctrl.sv
// Image-view controller: loads an IMG_W x IMG_H raster into a frame buffer
// and streams a WIN x WIN fit or zoom view, optionally mirrored.
module lcd_view_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 12,
    parameter int IMG_H = 9,
    parameter int WIN   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          busy
);

    localparam int N      = IMG_W * IMG_H;
    localparam int AW     = $clog2(N);
    localparam int XW     = $clog2(IMG_W + 1);
    localparam int YW     = $clog2(IMG_H + 1);
    localparam int CW     = $clog2(WIN);
    localparam int PIX    = WIN * WIN;
    localparam int KW     = $clog2(PIX + 1);
    localparam int HALF   = WIN / 2;
    localparam int SX     = IMG_W / WIN;
    localparam int SY     = IMG_H / WIN;
    localparam int OX_MIN = HALF;
    localparam int OX_MAX = IMG_W - HALF;
    localparam int OY_MIN = HALF;
    localparam int OY_MAX = IMG_H - HALF;
    localparam int OX_RST = IMG_W / 2;
    localparam int OY_RST = IMG_H / 2;

    localparam logic [2:0] CMD_LOAD     = 3'd0;
    localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
    localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
    localparam logic [2:0] CMD_RIGHT    = 3'd3;
    localparam logic [2:0] CMD_LEFT     = 3'd4;
    localparam logic [2:0] CMD_UP       = 3'd5;
    localparam logic [2:0] CMD_DOWN     = 3'd6;
    localparam logic [2:0] CMD_MIRROR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE_EMPTY,
        LOADING,
        OUTPUT,
        READY
    } state_t;

    typedef enum logic {
        FIT,
        ZOOM
    } mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic          mirror_q, mirror_d;
    logic [XW-1:0] ox_q, ox_d;
    logic [YW-1:0] oy_q, oy_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          start_load;
    logic          start_burst;
    logic          mem_we;
    logic [CW-1:0] cm;
    logic [AW-1:0] px;
    logic [AW-1:0] py;
    logic [AW-1:0] addr;

    logic [DW-1:0] mem [N];

    assign accept = cmd_valid && !busy_q;

    // Mirroring is applied to the column index before either view mapping.
    always_comb begin
        cm = mirror_q ? (CW'(WIN - 1) - col_q) : col_q;
        if (mode_q == ZOOM) begin
            px = AW'(ox_q) - AW'(HALF) + AW'(cm);
            py = AW'(oy_q) - AW'(HALF) + AW'(row_q);
        end else begin
            px = AW'(SX / 2) + AW'(cm) * AW'(SX);
            py = AW'(SY / 2) + AW'(row_q) * AW'(SY);
        end
        addr = py * AW'(IMG_W) + px;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ld_cnt_q] <= datain;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mirror_d    = mirror_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        ld_cnt_d    = ld_cnt_q;
        k_d         = k_q;
        col_d       = col_q;
        row_d       = row_q;
        dout_d      = dout_q;
        vld_d       = 1'b0;
        busy_d      = busy_q;
        start_load  = 1'b0;
        start_burst = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE_EMPTY: begin
                if (accept && cmd == CMD_LOAD) begin
                    start_load = 1'b1;
                end
            end
            LOADING: begin
                mem_we = 1'b1;
                if (ld_cnt_q == AW'(N - 1)) begin
                    start_burst = 1'b1;
                end else begin
                    ld_cnt_d = ld_cnt_q + AW'(1);
                end
            end
            OUTPUT: begin
                if (k_q == KW'(PIX)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end else begin
                    dout_d = mem[addr];
                    vld_d  = 1'b1;
                    k_d    = k_q + KW'(1);
                    if (col_q == CW'(WIN - 1)) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            READY: begin
                if (accept) begin
                    start_burst = 1'b1;
                    unique case (cmd)
                        CMD_LOAD: begin
                            start_burst = 1'b0;
                            start_load  = 1'b1;
                        end
                        CMD_ZOOM_IN: begin
                            if (mode_q == FIT) begin
                                ox_d = XW'(OX_RST);
                                oy_d = YW'(OY_RST);
                            end
                            mode_d = ZOOM;
                        end
                        CMD_ZOOM_FIT: begin
                            mode_d = FIT;
                        end
                        CMD_RIGHT: begin
                            if (mode_q == ZOOM && ox_q < XW'(OX_MAX)) begin
                                ox_d = ox_q + XW'(1);
                            end
                        end
                        CMD_LEFT: begin
                            if (mode_q == ZOOM && ox_q > XW'(OX_MIN)) begin
                                ox_d = ox_q - XW'(1);
                            end
                        end
                        CMD_UP: begin
                            if (mode_q == ZOOM && oy_q > YW'(OY_MIN)) begin
                                oy_d = oy_q - YW'(1);
                            end
                        end
                        CMD_DOWN: begin
                            if (mode_q == ZOOM && oy_q < YW'(OY_MAX)) begin
                                oy_d = oy_q + YW'(1);
                            end
                        end
                        CMD_MIRROR: begin
                            mirror_d = !mirror_q;
                        end
                    endcase
                end
            end
        endcase

        if (start_load) begin
            state_d  = LOADING;
            busy_d   = 1'b1;
            ld_cnt_d = '0;
            mode_d   = FIT;
            mirror_d = 1'b0;
        end
        if (start_burst) begin
            state_d = OUTPUT;
            busy_d  = 1'b1;
            k_d     = '0;
            col_d   = '0;
            row_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE_EMPTY;
            mode_q   <= FIT;
            mirror_q <= 1'b0;
            ox_q     <= XW'(OX_RST);
            oy_q     <= YW'(OY_RST);
            ld_cnt_q <= '0;
            k_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            dout_q   <= '0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mirror_q <= mirror_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            ld_cnt_q <= ld_cnt_d;
            k_q      <= k_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
        end
    end

    assign dataout      = dout_q;
    assign output_valid = vld_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_lcd_view_ctrl.sv
// Bench for lcd_view_ctrl: command table with expected view geometry,
// pixel scoreboard, and hand sequences for idle, busy-gating and reset cases.
module tb_lcd_view_ctrl;

    localparam int DW    = 8;
    localparam int IMG_W = 12;
    localparam int IMG_H = 9;
    localparam int WIN   = 4;
    localparam int N     = IMG_W * IMG_H;
    localparam int PIX   = WIN * WIN;
    localparam int SX    = IMG_W / WIN;
    localparam int SY    = IMG_H / WIN;
    localparam int HALF  = WIN / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] datain;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] img [N];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic [2:0] cmd;
        bit         fit;
        int         ox;
        int         oy;
        bit         mir;
        int         seed;
        bit         poke;
    } vec_t;

    vec_t vecs [$];

    lcd_view_ctrl #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .datain(datain),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .dataout(dataout),
        .output_valid(output_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && output_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got %0d, expected none", dataout);
            end else begin
                check("pixel", int'(dataout), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic add(input logic [2:0] c, input bit f, input int x,
                       input int y, input bit m, input int s, input bit p);
        vec_t v;
        v.cmd = c; v.fit = f; v.ox = x; v.oy = y;
        v.mir = m; v.seed = s; v.poke = p;
        vecs.push_back(v);
    endtask

    task automatic push_burst(input vec_t v);
        int cc, x, y;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                cc = v.mir ? (WIN - 1 - c) : c;
                if (v.fit) begin
                    x = SX / 2 + cc * SX;
                    y = SY / 2 + r * SY;
                end else begin
                    x = v.ox - HALF + cc;
                    y = v.oy - HALF + r;
                end
                exp_q.push_back(img[y * IMG_W + x]);
            end
        end
    endtask

    task automatic fill_img(input int seed);
        for (int i = 0; i < N; i++) begin
            img[i] = DW'(i * (seed + 1) + seed);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int b, first, fall;
        if (v.cmd == 3'd0) fill_img(v.seed);
        push_burst(v);
        b = (v.cmd == 3'd0) ? N + 1 : 1;
        first = -1;
        fall = -1;
        @(negedge clk);
        cmd = v.cmd;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        check("busy_at_accept", int'(busy), 1);
        for (int e = 1; e <= N + PIX + 40; e++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (v.cmd == 3'd0 && e <= N) datain = img[e - 1];
            if (v.poke && e == 5) begin
                cmd = 3'd3;
                cmd_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (output_valid && first < 0) first = e;
            if (!busy) begin
                fall = e;
                break;
            end
        end
        check("first_valid_edge", first, b);
        check("busy_fall_edge", fall, b + PIX);
        check("valid_low_after_burst", int'(output_valid), 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle_watch(input logic [2:0] c, input string name);
        int bad;
        bad = 0;
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (busy || output_valid) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        reset = 1'b1;
        datain = '0;
        cmd = 3'd0;
        cmd_valid = 1'b0;

        // cmd, fit, ox, oy, mirror, load seed, poke during burst
        add(3'd0, 1, 0, 0, 0, 0, 0);
        add(3'd1, 0, 6, 4, 0, 0, 0);
        add(3'd3, 0, 7, 4, 0, 0, 1);
        add(3'd3, 0, 8, 4, 0, 0, 0);
        add(3'd3, 0, 9, 4, 0, 0, 0);
        add(3'd3, 0, 10, 4, 0, 0, 0);
        add(3'd3, 0, 10, 4, 0, 0, 0);
        add(3'd7, 0, 10, 4, 1, 0, 0);
        add(3'd2, 1, 0, 0, 1, 0, 0);
        add(3'd4, 1, 0, 0, 1, 0, 0);
        add(3'd1, 0, 6, 4, 1, 0, 0);
        add(3'd6, 0, 6, 5, 1, 0, 0);
        add(3'd6, 0, 6, 6, 1, 0, 0);
        add(3'd6, 0, 6, 7, 1, 0, 0);
        add(3'd6, 0, 6, 7, 1, 0, 1);
        add(3'd5, 0, 6, 6, 1, 0, 0);
        add(3'd7, 0, 6, 6, 0, 0, 0);
        add(3'd4, 0, 5, 6, 0, 0, 0);
        add(3'd4, 0, 4, 6, 0, 0, 0);
        add(3'd4, 0, 3, 6, 0, 0, 0);
        add(3'd4, 0, 2, 6, 0, 0, 0);
        add(3'd4, 0, 2, 6, 0, 0, 0);
        add(3'd1, 0, 2, 6, 0, 0, 0);
        add(3'd0, 1, 0, 0, 0, 1, 0);
        add(3'd1, 0, 6, 4, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_dataout", int'(dataout), 0);
        check("reset_output_valid", int'(output_valid), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int c = 1; c < 8; c++) begin
            idle_watch(3'(c), "idle_ignore");
        end

        foreach (vecs[i]) begin
            run_cmd(vecs[i]);
        end

        fill_img(2);
        @(negedge clk);
        cmd = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 50; e++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            datain = img[e - 1];
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midload_reset_dataout", int'(dataout), 0);
        check("midload_reset_valid", int'(output_valid), 0);
        check("midload_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        idle_watch(3'd5, "up_after_reset_ignored");
        check("no_stray_expect", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
